// File: rtl/sr_ignition_controller.sv
// SR ignition sequencer. It qualifies sustained ignition sensitivity with
// hysteresis and then arms. On an SR trigger it drives a rise/hold/fall gain
// envelope, followed by a refractory lockout. All state advances on clk_en ticks.
module sr_ignition_controller #(
  parameter int WIDTH         = 18,
  parameter int FRAC          = 14,
  parameter int ARM_THRESH    = 8192,
  parameter int DISARM_THRESH = 6554,
  parameter int ARM_HOLD      = 16,
  parameter int WARMUP        = 8,
  parameter int RAMP_STEP     = 1024,
  parameter int IGNITE_HOLD   = 64,
  parameter int REFRACTORY    = 128,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] ignition_sensitivity,
  input  logic                    sr_trigger,
  input  logic                    force_abort,
  output logic [2:0]              state,
  output logic                    armed,
  output logic                    ignition_active,
  output logic                    ignition_start,
  output logic signed [WIDTH-1:0] ignition_gain,
  output logic [CNT_W-1:0]        event_count,
  output logic [CNT_W-1:0]        missed_count
);

  // One shared phase counter. Only one of the warmup, qualify, hold and
  // refractory phases is active at a time, so they can share it.
  localparam int PH_W = 16;

  localparam logic signed [WIDTH-1:0] ARM_Q    = WIDTH'(ARM_THRESH);
  localparam logic signed [WIDTH-1:0] DISARM_Q = WIDTH'(DISARM_THRESH);
  localparam logic signed [WIDTH-1:0] ONE_Q    = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH:0]   ONE_X    = (WIDTH+1)'(1 << FRAC);
  localparam logic signed [WIDTH:0]   STEP_X   = (WIDTH+1)'(RAMP_STEP);

  localparam logic [PH_W-1:0] WARM_LAST = PH_W'(WARMUP - 1);
  localparam logic [PH_W-1:0] QUAL_DONE = PH_W'(ARM_HOLD);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(IGNITE_HOLD - 1);
  localparam logic [PH_W-1:0] REF_LAST  = PH_W'(REFRACTORY - 1);

  typedef enum logic [2:0] {
    S_WARMUP  = 3'd0,
    S_IDLE    = 3'd1,
    S_QUALIFY = 3'd2,
    S_ARMED   = 3'd3,
    S_RISE    = 3'd4,
    S_HOLD    = 3'd5,
    S_FALL    = 3'd6,
    S_REFRACT = 3'd7
  } state_t;

  state_t            st;
  logic [PH_W-1:0]   phase;
  logic              sens_arm, sens_keep, miss_tick;
  logic signed [WIDTH:0] gain_up, gain_dn;

  // Signed threshold tests. A negative sensitivity fails both of them.
  assign sens_arm  = ignition_sensitivity >= ARM_Q;
  assign sens_keep = ignition_sensitivity >= DISARM_Q;

  // Envelope arithmetic is one bit wider, so the clamp sees the overshoot.
  assign gain_up = {ignition_gain[WIDTH-1], ignition_gain} + STEP_X;
  assign gain_dn = {ignition_gain[WIDTH-1], ignition_gain} - STEP_X;

  // A trigger is lost when it arrives while enabled but not armed.
  // This includes the qualify tick that arms.
  assign miss_tick = sr_trigger && enable &&
                     (st == S_IDLE || st == S_QUALIFY || st == S_REFRACT);

  assign state           = st;
  assign armed           = (st == S_ARMED);
  assign ignition_active = (st == S_RISE) || (st == S_HOLD) || (st == S_FALL);

  // Sequencer FSM, gain envelope and saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= S_WARMUP;
      phase          <= '0;
      ignition_start <= 1'b0;
      ignition_gain  <= '0;
      event_count    <= '0;
      missed_count   <= '0;
    end else begin
      // The start pulse is one clk wide, even when clk_en is low.
      ignition_start <= 1'b0;
      if (clk_en) begin
        if (miss_tick && missed_count != '1)
          missed_count <= missed_count + 1'b1;

        case (st)
          S_WARMUP: begin
            if (phase == WARM_LAST) begin
              st    <= S_IDLE;
              phase <= '0;
            end else begin
              phase <= phase + 1'b1;
            end
          end

          S_IDLE: begin
            if (enable && sens_arm) begin
              st    <= S_QUALIFY;
              phase <= PH_W'(1);
            end
          end

          // Values between the two thresholds keep counting. This gives hysteresis.
          S_QUALIFY: begin
            if (!enable || !sens_keep) begin
              st <= S_IDLE;
            end else if (phase + 1'b1 == QUAL_DONE) begin
              st <= S_ARMED;
            end else begin
              phase <= phase + 1'b1;
            end
          end

          // A trigger wins over a disarm on the same tick.
          S_ARMED: begin
            if (sr_trigger) begin
              st             <= S_RISE;
              ignition_start <= 1'b1;
              if (event_count != '1)
                event_count <= event_count + 1'b1;
            end else if (!enable || !sens_keep) begin
              st <= S_IDLE;
            end
          end

          // On abort the gain freezes this tick. The ramp down starts in FALL.
          S_RISE: begin
            if (force_abort) begin
              st <= S_FALL;
            end else if (gain_up >= ONE_X) begin
              ignition_gain <= ONE_Q;
              st            <= S_HOLD;
              phase         <= '0;
            end else begin
              ignition_gain <= gain_up[WIDTH-1:0];
            end
          end

          S_HOLD: begin
            if (force_abort || phase == HOLD_LAST) begin
              st <= S_FALL;
            end else begin
              phase <= phase + 1'b1;
            end
          end

          S_FALL: begin
            if (gain_dn[WIDTH] || gain_dn == '0) begin
              ignition_gain <= '0;
              st            <= S_REFRACT;
              phase         <= '0;
            end else begin
              ignition_gain <= gain_dn[WIDTH-1:0];
            end
          end

          // After lockout the controller must requalify from IDLE.
          S_REFRACT: begin
            if (phase == REF_LAST) begin
              st    <= S_IDLE;
              phase <= '0;
            end else begin
              phase <= phase + 1'b1;
            end
          end

          default: st <= S_WARMUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sr_ignition_controller.sv
// Bench for sr_ignition_controller. Each step pushes its expected outputs to a
// scoreboard queue. After the clock edge the step pops that entry and compares
// it with the DUT outputs.
module tb_sr_ignition_controller;
  localparam int WIDTH = 18;
  localparam int CNT_W = 16;
  localparam int ONE   = 16384;

  logic clk = 1'b0;
  logic rst, clk_en, enable, sr_trigger, force_abort;
  logic signed [WIDTH-1:0] ignition_sensitivity;
  logic [2:0] state;
  logic armed, ignition_active, ignition_start;
  logic signed [WIDTH-1:0] ignition_gain;
  logic [CNT_W-1:0] event_count, missed_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sr_ignition_controller dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .enable(enable),
    .ignition_sensitivity(ignition_sensitivity),
    .sr_trigger(sr_trigger), .force_abort(force_abort),
    .state(state), .armed(armed), .ignition_active(ignition_active),
    .ignition_start(ignition_start), .ignition_gain(ignition_gain),
    .event_count(event_count), .missed_count(missed_count)
  );

  typedef struct {
    logic       r, ce, en;
    int         sens;
    logic       trig, ab;
    logic [2:0] st;
    logic       arm, act, start;
    int         gain, ev, miss;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[9];

  function automatic vec_t V(input logic r, ce, en, input int sens, input logic trig, ab,
                             input logic [2:0] st, input logic arm, act, start,
                             input int gain, ev, miss);
    vec_t v;
    v.r = r; v.ce = ce; v.en = en; v.sens = sens; v.trig = trig; v.ab = ab;
    v.st = st; v.arm = arm; v.act = act; v.start = start;
    v.gain = gain; v.ev = ev; v.miss = miss;
    return v;
  endfunction

  task automatic step(input vec_t v, input string nm);
    vec_t e;
    rst = v.r; clk_en = v.ce; enable = v.en; sr_trigger = v.trig; force_abort = v.ab;
    ignition_sensitivity = WIDTH'(v.sens);
    sb_q.push_back(v);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_checks++;
    if (state !== e.st || armed !== e.arm || ignition_active !== e.act ||
        ignition_start !== e.start || int'(ignition_gain) != e.gain ||
        int'(event_count) != e.ev || int'(missed_count) != e.miss) begin
      n_fail++;
      $display("FAIL %s @%0t: got st=%0d arm=%0b act=%0b start=%0b gain=%0d ev=%0d miss=%0d; expected st=%0d arm=%0b act=%0b start=%0b gain=%0d ev=%0d miss=%0d",
               nm, $time, state, armed, ignition_active, ignition_start, ignition_gain,
               event_count, missed_count, e.st, e.arm, e.act, e.start, e.gain, e.ev, e.miss);
    end
  endtask

  initial begin
    // Warmup vectors. Triggers and aborts during warmup must have no effect.
    for (int i = 0; i < 8; i++)
      tbl[i] = V(0,1,1,ONE,1,1, (i == 7) ? 3'd1 : 3'd0, 0,0,0, 0,0,0);
    tbl[8] = V(0,1,1,10000,0,0, 3'd2, 0,0,0, 0,0,0);

    step(V(1,1,1,ONE,0,0, 3'd0, 0,0,0, 0,0,0), "reset");
    for (int i = 0; i < 9; i++) step(tbl[i], "warmup");

    // Qualify count 2..16 with sensitivity between the thresholds.
    for (int q = 2; q <= 16; q++)
      step(V(0,1,1,7000,0,0, (q == 16) ? 3'd3 : 3'd2, q == 16,0,0, 0,0,0), "qualify_hyst");

    // Full event.
    step(V(0,1,1,7000,1,0, 3'd4, 0,1,1, 0,1,0), "trigger");
    step(V(0,0,1,7000,0,0, 3'd4, 0,1,0, 0,1,0), "start_clears_gated");
    for (int k = 1; k <= 16; k++)
      step(V(0,1,1,7000,0,0, (k == 16) ? 3'd5 : 3'd4, 0,1,0, 1024*k,1,0), "rise");
    for (int j = 1; j <= 64; j++) begin
      if (j == 10)
        for (int g = 0; g < 50; g++)
          step(V(0,0,1,7000,1,1, 3'd5, 0,1,0, ONE,1,0), "gated_hold");
      step(V(0,1,1,7000,j == 20,0, (j == 64) ? 3'd6 : 3'd5, 0,1,0, ONE,1,0), "hold");
    end
    for (int k = 1; k <= 16; k++)
      step(V(0,1,1,7000,k == 5,0, (k == 16) ? 3'd7 : 3'd6, 0,k != 16,0, ONE-1024*k,1,0), "fall");
    for (int j = 1; j <= 128; j++)
      step(V(0,1,1,ONE,0,0, (j == 128) ? 3'd1 : 3'd7, 0,0,0, 0,1,0), "refract");

    // A trigger in IDLE is counted as missed.
    step(V(0,1,1,0,1,0, 3'd1, 0,0,0, 0,1,1), "missed_idle");

    // Qualification drops when sensitivity falls below the disarm threshold.
    step(V(0,1,1,10000,0,0, 3'd2, 0,0,0, 0,1,1), "qual_start");
    for (int q = 0; q < 5; q++)
      step(V(0,1,1,7000,0,0, 3'd2, 0,0,0, 0,1,1), "qual_mid");
    step(V(0,1,1,6000,0,0, 3'd1, 0,0,0, 0,1,1), "qual_drop");

    // Requalify. Then trigger and disarm on the same ARMED tick.
    for (int q = 1; q <= 16; q++)
      step(V(0,1,1,10000,0,0, (q == 16) ? 3'd3 : 3'd2, q == 16,0,0, 0,1,1), "requal");
    step(V(0,1,0,0,1,0, 3'd4, 0,1,1, 0,2,1), "trig_beats_disarm");
    for (int k = 1; k <= 4; k++)
      step(V(0,1,0,0,0,0, 3'd4, 0,1,0, 1024*k,2,1), "rise_disabled");
    step(V(0,1,0,0,0,1, 3'd6, 0,1,0, 4096,2,1), "abort");
    for (int k = 1; k <= 4; k++)
      step(V(0,1,0,0,0,0, (k == 4) ? 3'd7 : 3'd6, 0,k != 4,0, 4096-1024*k,2,1), "abort_fall");
    for (int j = 1; j <= 128; j++)
      step(V(0,1,j == 3,0,j == 3,0, (j == 128) ? 3'd1 : 3'd7, 0,0,0, 0,2,(j >= 3) ? 2 : 1), "refract2");

    // A trigger on the arming tick is missed. The next trigger starts an event.
    for (int q = 1; q <= 16; q++)
      step(V(0,1,1,ONE,q == 16,0, (q == 16) ? 3'd3 : 3'd2, q == 16,0,0, 0,2,(q == 16) ? 3 : 2), "requal2");
    step(V(0,1,1,ONE,1,0, 3'd4, 0,1,1, 0,3,3), "trigger3");
    for (int k = 1; k <= 16; k++)
      step(V(0,1,1,ONE,0,0, (k == 16) ? 3'd5 : 3'd4, 0,1,0, 1024*k,3,3), "rise3");
    step(V(0,1,1,ONE,0,0, 3'd5, 0,1,0, ONE,3,3), "hold3");

    // Reset in HOLD wins even with clk_en low.
    step(V(1,0,1,ONE,0,0, 3'd0, 0,0,0, 0,0,0), "midop_reset");
    step(V(0,0,1,ONE,0,0, 3'd0, 0,0,0, 0,0,0), "post_reset_gated");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
